// File: rtl/pipo_load_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipo_load_arbiter_if
//  Purpose  : Request/data/ack bundle between two requesters, a consumer and
//             the shared parallel-in parallel-out load register.
//  Revision : 1.0  initial release
// ============================================================================
interface pipo_load_arbiter_if;
    logic       req0;
    logic [3:0] d0;
    logic       req1;
    logic [3:0] d1;
    logic       consume;
    logic       ack0;
    logic       ack1;
    logic [3:0] q;
    logic       q_valid;
    logic       owner;
    logic [7:0] load_cnt;

    modport master (
        output req0, d0, req1, d1, consume,
        input  ack0, ack1, q, q_valid, owner, load_cnt
    );

    modport slave (
        input  req0, d0, req1, d1, consume,
        output ack0, ack1, q, q_valid, owner, load_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipo_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipo_load_arbiter
//  Purpose  : Round-robin arbitration of two load requesters into one shared
//             4-bit register that stays occupied until the consumer frees it.
//  Revision : 1.0  initial release
// ============================================================================
module pipo_load_arbiter (
    input  wire logic          clk,
    input  wire logic          clear,
    pipo_load_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_grant;
    logic       w_winner;

    logic [3:0] r_q;
    logic       r_owner;
    logic       r_last_grant;
    logic [7:0] r_load_cnt;
    logic       r_ack0;
    logic       r_ack1;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A tie goes to whoever did not win last; a lone request wins outright.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_winner     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_grant      = 1'b1;
                    w_winner     = (bus.req0 && bus.req1) ? ~r_last_grant : bus.req1;
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (bus.consume) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_q          <= 4'b0000;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_load_cnt   <= 8'd0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            r_ack0 <= w_grant & ~w_winner;
            r_ack1 <= w_grant &  w_winner;
            if (w_grant) begin
                r_q          <= w_winner ? bus.d1 : bus.d0;
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_load_cnt   <= r_load_cnt + 8'd1;
            end
        end
    end

    assign bus.q        = r_q;
    assign bus.q_valid  = (r_state == FULL);
    assign bus.owner    = r_owner;
    assign bus.load_cnt = r_load_cnt;
    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;

endmodule
`default_nettype wire

// File: doc/pipo_load_arbiter.md
PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: clear  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req0  input  1  requester 0 load request; held until ack0.
REQ-004 SHALL have port: d0  input  4  requester 0 parallel data; stable while req0 high.
REQ-005 SHALL have port: req1  input  1  requester 1 load request; held until ack1.
REQ-006 SHALL have port: d1  input  4  requester 1 parallel data; stable while req1 high.
REQ-007 SHALL have port: consume  input  1  downstream has taken q; frees the register.
REQ-008 SHALL have port: ack0  output  1  one-cycle pulse; d0 captured.
REQ-009 SHALL have port: ack1  output  1  one-cycle pulse; d1 captured.
REQ-010 SHALL have port: q  output  4  shared parallel-in parallel-out register contents.
REQ-011 SHALL have port: q_valid  output  1  q holds unconsumed data.
REQ-012 SHALL have port: owner  output  1  requester index of the last capture.
REQ-013 SHALL have port: load_cnt  output  8  total captures since reset.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (register free) and FULL (register occupied); q_valid SHALL equal (state == FULL).
REQ-015 In IDLE, at a rising edge with req0 or req1 high, SHALL capture the winner's data into q, set owner to the winner, pulse that requester's ack high for exactly the following cycle, increment load_cnt, and move to FULL.
REQ-016 Load latency SHALL be one edge: a request sampled at edge N gives q, q_valid, and ack valid immediately after edge N.
REQ-017 Single request SHALL be granted directly; with both high, the winner SHALL be the requester other than last_grant (round robin), and last_grant SHALL update to the winner.
REQ-018 In FULL, q, owner, and load_cnt SHALL hold; requests SHALL be ignored, with no ack.
REQ-019 In FULL, consume high at an edge SHALL clear q_valid and return to IDLE; q SHALL keep its value.
REQ-020 Consume and a pending request at the same FULL edge SHALL go to IDLE only; the grant occurs at the next edge, giving a minimum of one IDLE cycle between captures.
REQ-021 Consume in IDLE SHALL be ignored.
REQ-022 ack0 and ack1 SHALL never be high in the same cycle.
REQ-023 load_cnt SHALL wrap from 255 to 0 without a flag.
REQ-024 A request dropped before its grant SHALL be forgotten, with no ack.

Reset
REQ-025 While clear is high, regardless of clk, SHALL force: state IDLE, q=4'b0000, q_valid=0, ack0=0, ack1=0, owner=0, load_cnt=0, last_grant=1 (req0 wins the first tie).
REQ-026 clear asserted in FULL or during an ack pulse SHALL abort the operation immediately: no ack completes and the data is discarded.
REQ-027 The first edge after clear deasserts SHALL behave as IDLE.

Verification
REQ-028 Reset: clear=1 for 5 ns with req0=1 -> all outputs 0 and no ack; after release, the first edge with req0=1, d0=4'b0011 -> q=0011, ack0 pulse, owner=0, load_cnt=1.
REQ-029 Tie sequence: req0=req1=1, d0=0111, d1=1011, consume one cycle after each ack -> grants 0,1,0,1 with q alternating 0111/1011 and load_cnt=4.
REQ-030 Hold: in FULL with req1=1, d1=1001, and consume=0 for 10 cycles -> q, owner, and load_cnt unchanged and ack1 stays 0; consume=1 -> q_valid=0 next edge, then ack1 one edge later.
REQ-031 Mid-operation reset: clear pulse while FULL with q=1111 -> q=0000 and q_valid=0 asynchronously, before the next clk edge.
REQ-032 Wrap: 256 captures of d0=0001 with consume after each -> load_cnt reads 0 and q=0001.
REQ-033 Bench SHALL assert every cycle that ack0&ack1==0, that q_valid implies state FULL, and that no ack occurs while q_valid=1 before consume.
